muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the instruction decoder.
- The decoder's M-extension decode selects the operation; the pipeline gates the decoder's muldiv start and select outputs into start_i.
- The unit computes one 32-bit result at a time: radix-2 shift-add for multiply, restoring division for divide.
- It reports completion with a single-cycle done pulse, which the pipeline uses to release its EX stall.

---
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// A radix-2 shift-add multiplier and a restoring divider share one FSM.
// Each engine works on unsigned magnitudes, and the signs are fixed up in FINAL.
// Division by zero and signed overflow resolve at capture and go straight to DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            is_div_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_next_s;
  logic [4:0]        cnt_r;
  logic              is_div_r;
  logic [1:0]        op_r;
  logic              a_neg_r, b_neg_r;
  logic [XLEN-1:0]   mag_a_r, mag_b_r;
  logic [2*XLEN-1:0] prod_r;
  logic [XLEN-1:0]   quo_r;
  logic [XLEN:0]     rem_r;
  logic              busy_r, done_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s, signed_a_s, signed_b_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic              fast_s;
  logic [XLEN-1:0]   fast_val_s;
  logic [XLEN:0]     mul_sum_s, rem_sh_s, rem_sub_s;
  logic              rem_ge_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, final_res_s;

  // Decode operand signedness and magnitudes, and detect the divide fast path.
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    fast_s     = 1'b0;
    fast_val_s = 32'h0000_0000;
    if (is_div_i) begin
      signed_a_s = ~op_i[0];
      signed_b_s = ~op_i[0];
    end else begin
      case (op_i)
        2'b00, 2'b01: begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
        2'b10:        begin signed_a_s = 1'b1; signed_b_s = 1'b0; end
        2'b11:        begin signed_a_s = 1'b0; signed_b_s = 1'b0; end
        default:      begin signed_a_s = 1'b0; signed_b_s = 1'b0; end
      endcase
    end
    a_neg_s = signed_a_s & a_i[XLEN-1];
    b_neg_s = signed_b_s & b_i[XLEN-1];
    a_mag_s = a_neg_s ? (~a_i + 32'd1) : a_i;
    b_mag_s = b_neg_s ? (~b_i + 32'd1) : b_i;
    if (!is_div_i) begin
      fast_s = 1'b0;
    end else if (b_i == 32'h0000_0000) begin
      fast_s     = 1'b1;
      fast_val_s = op_i[1] ? a_i : 32'hFFFF_FFFF;
    end else if (~op_i[0] && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
      fast_s     = 1'b1;
      fast_val_s = op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      fast_s = 1'b0;
    end
  end

  // Next-state logic. A kill drops any same-cycle start and aborts an operation in flight.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_i && !kill_i) begin
          accept_s     = 1'b1;
          state_next_s = fast_s ? S_DONE : S_ITER;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ITER: begin
        if (kill_i) begin
          state_next_s = S_IDLE;
        end else if (cnt_r == 5'd31) begin
          state_next_s = S_FINAL;
        end else begin
          state_next_s = S_ITER;
        end
      end
      S_FINAL: begin
        if (kill_i) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // One iteration step for each engine, plus the sign fix-up and result select used in FINAL.
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, mag_a_r} : 33'd0);
    rem_sh_s   = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
    rem_ge_s   = (rem_sh_s >= {1'b0, mag_b_r});
    rem_sub_s  = rem_sh_s - {1'b0, mag_b_r};
    prod_fix_s = (a_neg_r ^ b_neg_r) ? (~prod_r + 64'd1) : prod_r;
    quo_fix_s  = (a_neg_r ^ b_neg_r) ? (~quo_r + 32'd1) : quo_r;
    rem_fix_s  = a_neg_r ? (~rem_r[XLEN-1:0] + 32'd1) : rem_r[XLEN-1:0];
    case ({is_div_r, op_r})
      3'b000:                 final_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res_s = quo_fix_s;
      3'b110, 3'b111:         final_res_s = rem_fix_s;
      default:                final_res_s = 32'h0000_0000;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture and the iterative multiply/divide datapath.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r    <= 5'd0;
      is_div_r <= 1'b0;
      op_r     <= 2'b00;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      mag_a_r  <= 32'h0000_0000;
      mag_b_r  <= 32'h0000_0000;
      prod_r   <= 64'd0;
      quo_r    <= 32'h0000_0000;
      rem_r    <= 33'd0;
    end else if (accept_s) begin
      cnt_r    <= 5'd0;
      is_div_r <= is_div_i;
      op_r     <= op_i;
      a_neg_r  <= a_neg_s;
      b_neg_r  <= b_neg_s;
      mag_a_r  <= a_mag_s;
      mag_b_r  <= b_mag_s;
      prod_r   <= {32'h0000_0000, b_mag_s};
      quo_r    <= a_mag_s;
      rem_r    <= 33'd0;
    end else if (state_r == S_ITER) begin
      cnt_r <= cnt_r + 5'd1;
      if (is_div_r) begin
        quo_r <= {quo_r[XLEN-2:0], rem_ge_s};
        rem_r <= rem_ge_s ? rem_sub_s : rem_sh_s;
      end else begin
        prod_r <= {mul_sum_s, prod_r[XLEN-1:1]};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered status and result. The result changes only at a fast-path capture or on leaving FINAL.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'h0000_0000;
    end else begin
      busy_r <= (state_next_s == S_ITER) || (state_next_s == S_FINAL);
      done_r <= (state_next_s == S_DONE);
      if (accept_s && fast_s) begin
        result_r <= fast_val_s;
      end else if ((state_r == S_FINAL) && !kill_i) begin
        result_r <= final_res_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit, built around a scoreboard of expected results and done cycles.
module tb_muldiv_unit;

  logic        clk_i, reset_i, start_i, is_div_i, kill_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .is_div_i(is_div_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .kill_i  (kill_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic div, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic push, input logic [31:0] exp,
                       input int lat);
    is_div_i = div;
    op_i     = op;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    if (push) sb_q.push_back('{res: exp, cyc: cyc + lat});
    tick();
    start_i = 1'b0;
  endtask

  task automatic run(input logic div, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input logic fast);
    issue(div, op, a, b, 1'b1, exp, fast ? 1 : 34);
    if (fast) begin
      check32("fast_busy_t1", {31'd0, busy_o}, 32'd0);
      tick();
      check32("fast_busy_t2", {31'd0, busy_o}, 32'd0);
    end else begin
      repeat (34) tick();
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected result and its cycle.
  always @(negedge clk_i) begin
    if (mon_en) begin
      check32("busy_done_excl", {31'd0, busy_o & done_o}, 32'd0);
      if (done_o) begin
        check32("unexpected_done", sb_q.size(), 32'd1 * (sb_q.size() == 0 ? 32'd1 : sb_q.size()));
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check32("done_result", result_o, mon_e.res);
          check32("done_cycle", cyc, mon_e.cyc);
        end else begin
          check32("spurious_done", {31'd0, done_o}, 32'd0);
        end
      end
    end
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    is_div_i = 1'b0; op_i = 2'b00; a_i = 32'd0; b_i = 32'd0;
    repeat (3) tick();
    check32("rst_busy", {31'd0, busy_o}, 32'd0);
    check32("rst_done", {31'd0, done_o}, 32'd0);
    check32("rst_result", result_o, 32'd0);
    reset_i = 1'b0;
    mon_en  = 1'b1;
    tick();

    // MUL 7 * -3: busy profile and result hold.
    issue(1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 34);
    for (int i = 1; i <= 40; i++) begin
      check32("mul_busy", {31'd0, busy_o}, (i <= 33) ? 32'd1 : 32'd0);
      if (i >= 34) check32("mul_hold", result_o, 32'hFFFF_FFEB);
      tick();
    end

    // Multiply high-half variants.
    run(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run(1'b0, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);

    // Divide and remainder, signed and unsigned.
    run(1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run(1'b1, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run(1'b1, 2'b01, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
    run(1'b1, 2'b11, 32'd100, 32'd7, 32'h0000_0002, 1'b0);

    // Fast path: divide by zero and signed overflow.
    run(1'b1, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run(1'b1, 2'b11, 32'd5, 32'd0, 32'h0000_0005, 1'b1);
    run(1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

    // Kill at T+10, followed by MUL 3*4 at T+12.
    issue(1'b1, 2'b01, 32'd1000, 32'd3, 1'b0, 32'd0, 0);
    repeat (9) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check32("kill_busy", {31'd0, busy_o}, 32'd0);
    tick();
    issue(1'b0, 2'b00, 32'd3, 32'd4, 1'b1, 32'h0000_000C, 34);
    repeat (40) tick();

    // Start ignored while busy, then reset mid-operation.
    issue(1'b0, 2'b00, 32'd9, 32'd9, 1'b0, 32'd0, 0);
    repeat (4) tick();
    is_div_i = 1'b1; op_i = 2'b00; a_i = 32'd5; b_i = 32'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (14) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check32("midrst_busy", {31'd0, busy_o}, 32'd0);
    check32("midrst_done", {31'd0, done_o}, 32'd0);
    check32("midrst_result", result_o, 32'd0);
    repeat (40) tick();

    // Back-to-back: second start issued in the DONE cycle of the first.
    issue(1'b0, 2'b00, 32'd6, 32'd7, 1'b1, 32'd42, 34);
    repeat (33) tick();
    check32("b2b_done_cycle", {31'd0, done_o}, 32'd1);
    issue(1'b1, 2'b01, 32'd50, 32'd5, 1'b1, 32'd10, 34);

    // Bounded drain of outstanding results.
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() != 0) tick();
    end
    tick();
    check32("drain", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
